// File: rtl/hamming_univ_shift_reg_pkg.sv
// Shared definitions for the Hamming-protected universal shift register.
// Contents:
//   mode_e  - operating mode encoding (SISO, SIPO, PISO, PIPO)
//   calc_p  - number of Hamming check bits needed for a given data width
//   code_w  - full SEC-DED codeword width (data + check bits + overall parity)
package hamming_univ_pkg;

  typedef enum logic [1:0] {
    MODE_SISO = 2'b00,
    MODE_SIPO = 2'b01,
    MODE_PISO = 2'b10,
    MODE_PIPO = 2'b11
  } mode_e;

  // Smallest p with 2^p >= width + p + 1.
  function automatic int calc_p(input int width);
    int p;
    p = 1;
    while ((1 << p) < width + p + 1) p++;
    return p;
  endfunction

  function automatic int code_w(input int width);
    return width + calc_p(width) + 1;
  endfunction

endpackage

// File: rtl/hamming_univ_shift_reg_if.sv
// Bus interface of hamming_univ_shift_reg.
// master: drives the control/data inputs and observes the outputs.
// slave : the register itself.
// Signals: enable, mode, load, shift_left, serial_in, parallel_in, err_clr (to slave);
//          serial_out, parallel_out, sec_err, ded_err, ded_sticky, sec_count,
//          ded_count (from slave).
interface hamming_univ_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             enable;
  logic [1:0]       mode;
  logic             load;
  logic             shift_left;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic             err_clr;
  logic             serial_out;
  logic [WIDTH-1:0] parallel_out;
  logic             sec_err;
  logic             ded_err;
  logic             ded_sticky;
  logic [CNT_W-1:0] sec_count;
  logic [CNT_W-1:0] ded_count;

  modport master (
    output enable, mode, load, shift_left, serial_in, parallel_in, err_clr,
    input  serial_out, parallel_out, sec_err, ded_err, ded_sticky, sec_count, ded_count
  );

  modport slave (
    input  enable, mode, load, shift_left, serial_in, parallel_in, err_clr,
    output serial_out, parallel_out, sec_err, ded_err, ded_sticky, sec_count, ded_count
  );
endinterface

// File: rtl/hamming_univ_shift_reg_codec.sv
// hamming_secded_codec: purely combinational SEC-DED Hamming codec.
// Codeword layout: bit 0 is overall parity, bits 1..N are Hamming positions,
// check bits sit at power-of-two positions, data fills the rest in ascending order.
// Ports:
//   data_in  -> code_out : encoder
//   code_in  -> data_out : decoder with single-error correction
//   sec      : single error (including a lone overall-parity error)
//   ded      : uncorrectable double error
module hamming_secded_codec
  import hamming_univ_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]          data_in,
  output logic [code_w(WIDTH)-1:0]  code_out,
  input  logic [code_w(WIDTH)-1:0]  code_in,
  output logic [WIDTH-1:0]          data_out,
  output logic                      sec,
  output logic                      ded
);
  localparam int P  = calc_p(WIDTH);
  localparam int N  = WIDTH + P;
  localparam int CW = N + 1;

  logic [P-1:0]  syn;
  logic          par_err;
  logic [CW-1:0] fixed;

  always_comb begin
    int  j;
    logic pbit;
    code_out = '0;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        code_out[i] = data_in[j];
        j++;
      end
    end
    for (int k = 0; k < P; k++) begin
      pbit = 1'b0;
      for (int i = 1; i <= N; i++) begin
        if ((((i >> k) & 1) == 1) && (i != (1 << k))) pbit ^= code_out[i];
      end
      code_out[1 << k] = pbit;
    end
    code_out[0] = ^code_out[CW-1:1];
  end

  always_comb begin
    int j;
    syn = '0;
    for (int i = 1; i <= N; i++) begin
      if (code_in[i]) syn ^= i[P-1:0];
    end
    par_err = ^code_in;
    fixed   = code_in;
    // A syndrome pointing past the codeword cannot come from a single flip.
    if (par_err && syn != '0 && int'(syn) <= N) fixed[syn] = ~fixed[syn];
    sec = par_err && (int'(syn) <= N);
    ded = (!par_err && syn != '0) || (par_err && int'(syn) > N);
    data_out = '0;
    j = 0;
    for (int i = 1; i <= N; i++) begin
      if ((i & (i - 1)) != 0) begin
        data_out[j] = fixed[i];
        j++;
      end
    end
  end
endmodule

// File: rtl/hamming_univ_shift_reg.sv
// hamming_univ_shift_reg: universal shift register (SISO/SIPO/PISO/PIPO) whose
// state is stored as a SEC-DED codeword and scrubbed every cycle.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   bus      : slave side of hamming_univ_shift_reg_if (controls, serial/parallel
//              data, error pulses, sticky DED flag and saturating error counters)
module hamming_univ_shift_reg
  import hamming_univ_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  hamming_univ_shift_reg_if.slave bus
);
  localparam int CW = code_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CW-1:0]    reg_code;
  logic [CW-1:0]    next_code;
  logic [CW-1:0]    dec_unused_code;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_data;
  logic [WIDTH-1:0] enc_unused_data;
  logic [WIDTH-1:0] par_q;
  logic             dec_sec, dec_ded;
  logic             enc_unused_sec, enc_unused_ded;
  logic             do_load, write_en, par_upd;
  logic             sec_q, ded_q, sticky_q;
  logic [CNT_W-1:0] sec_cnt, ded_cnt;
  mode_e            mode;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic ev, input logic clr);
    if (clr) return ev ? CNT_W'(1) : '0;
    if (ev && cur != CNT_MAX) return cur + CNT_W'(1);
    return cur;
  endfunction

  hamming_secded_codec #(.WIDTH(WIDTH)) u_dec (
    .data_in  ('0),
    .code_out (dec_unused_code),
    .code_in  (reg_code),
    .data_out (d),
    .sec      (dec_sec),
    .ded      (dec_ded)
  );

  hamming_secded_codec #(.WIDTH(WIDTH)) u_enc (
    .data_in  (next_data),
    .code_out (next_code),
    .code_in  ('0),
    .data_out (enc_unused_data),
    .sec      (enc_unused_sec),
    .ded      (enc_unused_ded)
  );

  always_comb begin
    mode      = mode_e'(bus.mode);
    shifted   = bus.shift_left ? {d[WIDTH-2:0], bus.serial_in}
                               : {bus.serial_in, d[WIDTH-1:1]};
    do_load   = bus.enable && bus.load && (mode == MODE_PISO || mode == MODE_PIPO);
    next_data = d;
    if (do_load) begin
      next_data = bus.parallel_in;
    end else if (bus.enable) begin
      case (mode)
        MODE_SISO, MODE_SIPO, MODE_PISO: next_data = shifted;
        default:                         next_data = d;
      endcase
    end
    // A double error freezes the codeword; only a fresh load may replace it.
    write_en = do_load || !dec_ded;
    par_upd  = write_en && (mode == MODE_SIPO || mode == MODE_PIPO);
  end

  // Stage boundary: codeword, parallel output and error bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_code <= '0;
      par_q    <= '0;
      sec_q    <= 1'b0;
      ded_q    <= 1'b0;
      sticky_q <= 1'b0;
      sec_cnt  <= '0;
      ded_cnt  <= '0;
    end else begin
      if (write_en) reg_code <= next_code;
      if (par_upd)  par_q    <= next_data;
      sec_q    <= dec_sec;
      ded_q    <= dec_ded;
      sticky_q <= dec_ded | (sticky_q & ~bus.err_clr);
      sec_cnt  <= cnt_next(sec_cnt, dec_sec, bus.err_clr);
      ded_cnt  <= cnt_next(ded_cnt, dec_ded, bus.err_clr);
    end
  end

  assign bus.serial_out   = bus.shift_left ? d[WIDTH-1] : d[0];
  assign bus.parallel_out = par_q;
  assign bus.sec_err      = sec_q;
  assign bus.ded_err      = ded_q;
  assign bus.ded_sticky   = sticky_q;
  assign bus.sec_count    = sec_cnt;
  assign bus.ded_count    = ded_cnt;
endmodule

// File: tb/tb_hamming_univ_shift_reg.sv
// Directed bench for hamming_univ_shift_reg (WIDTH=8, CNT_W=2).
// Codeword constants: encode(8'hA5) = 13'h144E, encode(8'h3C) = 13'h06C5.
module tb_hamming_univ_shift_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  hamming_univ_shift_reg_if #(.WIDTH(8), .CNT_W(2)) bus ();

  hamming_univ_shift_reg #(.WIDTH(8), .CNT_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Corrupt the stored codeword for the remainder of the current cycle.
  task automatic inject(input logic [12:0] code);
    force dut.reg_code = code;
    #1;
    release dut.reg_code;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0]  sipo_r [4];
    logic [7:0]  sipo_l [4];
    logic [3:0]  sin_seq;
    logic [7:0]  piso_v;
    logic [12:0] inj;

    sipo_r  = '{8'h80, 8'h40, 8'hA0, 8'hD0};
    sipo_l  = '{8'h01, 8'h02, 8'h05, 8'h0B};
    sin_seq = 4'b1101; // applied LSB first: 1,0,1,1
    piso_v  = 8'hDB;

    bus.enable = 1'b1; bus.mode = 2'b11; bus.load = 1'b1; bus.shift_left = 1'b0;
    bus.serial_in = 1'b1; bus.parallel_in = 8'hFF; bus.err_clr = 1'b1;

    // Reset overrides enable/load/err_clr.
    rst = 1'b1;
    step();
    step();
    chk("rst_pout", bus.parallel_out, 8'h00);
    chk("rst_sout", bus.serial_out, 1'b0);
    chk("rst_code", dut.reg_code, 13'h0000);
    chk("rst_seccnt", bus.sec_count, 2'd0);
    chk("rst_dedcnt", bus.ded_count, 2'd0);
    chk("rst_sticky", bus.ded_sticky, 1'b0);
    chk("rst_secerr", bus.sec_err, 1'b0);
    chk("rst_dederr", bus.ded_err, 1'b0);
    rst = 1'b0;
    bus.load = 1'b0; bus.err_clr = 1'b0;

    // SIPO right shift.
    bus.mode = 2'b01; bus.shift_left = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.serial_in = sin_seq[i];
      step();
      chk($sformatf("sipo_r%0d", i), bus.parallel_out, sipo_r[i]);
    end

    // SIPO left shift from zero.
    do_reset();
    bus.shift_left = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.serial_in = sin_seq[i];
      step();
      chk($sformatf("sipo_l%0d", i), bus.parallel_out, sipo_l[i]);
    end
    chk("sout_left_msb", bus.serial_out, 1'b0);

    // Reset mid-shift discards state.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_pout", bus.parallel_out, 8'h00);
    chk("midrst_code", dut.reg_code, 13'h0000);

    // PISO: load then shift out LSB first; parallel_out stays put.
    bus.mode = 2'b10; bus.shift_left = 1'b0; bus.serial_in = 1'b0;
    bus.load = 1'b1; bus.parallel_in = 8'hDB;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("piso_sout%0d", i), bus.serial_out, piso_v[i]);
      step();
    end
    chk("piso_pout", bus.parallel_out, 8'h00);

    // Scrub while idle.
    do_reset();
    bus.mode = 2'b11; bus.load = 1'b1; bus.parallel_in = 8'hA5;
    step();
    chk("pipo_pout", bus.parallel_out, 8'hA5);
    chk("pipo_code", dut.reg_code, 13'h144E);
    bus.enable = 1'b0; bus.load = 1'b0;
    inject(13'h140E);
    chk("scrub_sout", bus.serial_out, 1'b1);
    step();
    chk("scrub_secerr", bus.sec_err, 1'b1);
    chk("scrub_seccnt", bus.sec_count, 2'd1);
    chk("scrub_code", dut.reg_code, 13'h144E);
    chk("scrub_pout", bus.parallel_out, 8'hA5);
    chk("scrub_dederr", bus.ded_err, 1'b0);
    step();
    chk("scrub_secerr_end", bus.sec_err, 1'b0);
    chk("scrub_seccnt_hold", bus.sec_count, 2'd1);

    // Double error in SISO: shift suppressed, codeword frozen.
    do_reset();
    bus.enable = 1'b1; bus.mode = 2'b00; bus.serial_in = 1'b1; bus.shift_left = 1'b0;
    inject(13'h0028);
    step();
    chk("ded_err", bus.ded_err, 1'b1);
    chk("ded_cnt1", bus.ded_count, 2'd1);
    chk("ded_sticky", bus.ded_sticky, 1'b1);
    chk("ded_held", dut.reg_code, 13'h0028);
    chk("ded_noscerr", bus.sec_err, 1'b0);
    bus.mode = 2'b11; bus.load = 1'b1; bus.parallel_in = 8'h3C;
    step();
    chk("ded_load_pout", bus.parallel_out, 8'h3C);
    chk("ded_load_code", dut.reg_code, 13'h06C5);
    chk("ded_cnt2", bus.ded_count, 2'd2);
    bus.load = 1'b0;
    step();
    chk("ded_err_end", bus.ded_err, 1'b0);
    chk("ded_sticky_hold", bus.ded_sticky, 1'b1);
    bus.err_clr = 1'b1;
    step();
    bus.err_clr = 1'b0;
    chk("ded_sticky_clr", bus.ded_sticky, 1'b0);
    chk("ded_cnt_clr", bus.ded_count, 2'd0);

    // Saturating SEC counter.
    do_reset();
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inj = 13'h0001 << (i * 3);
      inject(inj);
      step();
      chk($sformatf("sat_secerr%0d", i), bus.sec_err, 1'b1);
      chk($sformatf("sat_code%0d", i), dut.reg_code, 13'h0000);
    end
    chk("sat_cnt", bus.sec_count, 2'd3);
    bus.err_clr = 1'b1;
    inject(13'h0020);
    step();
    bus.err_clr = 1'b0;
    chk("sat_clr_cnt", bus.sec_count, 2'd1);
    chk("sat_clr_secerr", bus.sec_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
